// File: rtl/alu_loader_pkg.sv
// Shared types and sizing for the ALU operand loader.
// Used by alu_operand_loader and, when ALU_LOADER_TIMEOUT_EN is defined, alu_loader_timer.
package alu_loader_pkg;

  localparam int OPERAND_W = 8;
  localparam int SEL_W = 3;
  localparam int TIMER_W = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_loader_timer.sv
// Stall timer for partial operand loads; only built when ALU_LOADER_TIMEOUT_EN is defined.
// expire flags the enabled edge on which TIMEOUT_CYCLES strobe-less cycles will have elapsed.
`ifdef ALU_LOADER_TIMEOUT_EN
module alu_loader_timer
  import alu_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic count_en,
  input  logic clear,
  output logic expire
);

  logic [TIMER_W-1:0] count;

  assign expire = count_en && !clear && (count == TIMER_W'(TIMEOUT_CYCLES - 1));

  // Restart from zero on any strobe, on expiry, or whenever the FSM is outside a load state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (ena) begin
      if (clear || !count_en || expire) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/alu_operand_loader.sv
// Collects header/A/B bytes from a strobed bus, presents them to an external ALU and latches the result.
// Define ALU_LOADER_TIMEOUT_EN to abort stalled loads after TIMEOUT_CYCLES enabled cycles.
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [OPERAND_W-1:0] din,
  input  logic                 strobe,
  output logic [OPERAND_W-1:0] alu_a,
  output logic [OPERAND_W-1:0] alu_b,
  output logic [SEL_W-1:0]     alu_sel,
  input  logic [OPERAND_W-1:0] alu_result,
  input  logic                 alu_cout,
  output logic [OPERAND_W-1:0] dout,
  output logic                 dout_cout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 err
);

  state_t               state;
  logic [OPERAND_W-1:0] a_reg;
  logic [OPERAND_W-1:0] b_reg;
  logic [SEL_W-1:0]     sel_reg;
  logic                 timeout_hit;

  assign alu_a   = a_reg;
  assign alu_b   = b_reg;
  assign alu_sel = sel_reg;

`ifdef ALU_LOADER_TIMEOUT_EN
  alu_loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .count_en ((state == ST_GET_A) || (state == ST_GET_B)),
    .clear    (strobe),
    .expire   (timeout_hit)
  );

  // err is a one-cycle pulse and must read 0 on any cycle where ena is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= ena && timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // busy and dout_valid are registered alongside the state so they never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      dout       <= '0;
      dout_cout  <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            sel_reg <= din[SEL_W-1:0];
            state   <= ST_GET_A;
            busy    <= 1'b1;
          end
        end
        ST_GET_A: begin
          if (strobe) begin
            a_reg <= din;
            state <= ST_GET_B;
          end else if (timeout_hit) begin
            a_reg <= '0;
            b_reg <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_GET_B: begin
          if (strobe) begin
            b_reg <= din;
            state <= ST_EXEC;
          end else if (timeout_hit) begin
            a_reg <= '0;
            b_reg <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_EXEC: begin
          dout       <= alu_result;
          dout_cout  <= alu_cout;
          dout_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          // A strobe here is the header of the next operation.
          if (strobe) begin
            sel_reg    <= din[SEL_W-1:0];
            dout_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_GET_A;
          end
        end
        default: begin
          state      <= ST_IDLE;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed self-checking bench for alu_operand_loader with an 8-bit adder standing in for the ALU.
// Timeout expectations follow ALU_LOADER_TIMEOUT_EN.
module tb_alu_operand_loader;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] din;
  logic       strobe;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_cout;
  logic [7:0] dout;
  logic       dout_cout;
  logic       dout_valid;
  logic       busy;
  logic       err;
  logic [8:0] alu_sum;

  int checks = 0;
  int errors = 0;

  alu_operand_loader #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .din        (din),
    .strobe     (strobe),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .dout       (dout),
    .dout_cout  (dout_cout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .err        (err)
  );

  // External ALU: 8-bit add with carry out.
  assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_result = alu_sum[7:0];
  assign alu_cout   = alu_sum[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobed byte; returns at the falling edge right after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    din    = b;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    din    = 8'h00;
  endtask

  task automatic test_reset;
    rst = 1'b1; ena = 1'b1; strobe = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin $display("[TB] FAIL reset_busy got %b exp 0", busy); errors++; end
    checks++; if (dout_valid !== 1'b0) begin $display("[TB] FAIL reset_valid got %b exp 0", dout_valid); errors++; end
    checks++; if (err !== 1'b0) begin $display("[TB] FAIL reset_err got %b exp 0", err); errors++; end
    checks++; if ({alu_a, alu_b, alu_sel} !== 19'h0) begin $display("[TB] FAIL reset_operands got %h %h %h exp 0", alu_a, alu_b, alu_sel); errors++; end
    checks++; if ({dout, dout_cout} !== 9'h0) begin $display("[TB] FAIL reset_dout got %h/%b exp 00/0", dout, dout_cout); errors++; end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_add;
    send_byte(8'h01);
    checks++; if (busy !== 1'b1) begin $display("[TB] FAIL basic_busy_hdr got %b exp 1", busy); errors++; end
    send_byte(8'h0F);
    send_byte(8'h11);
    checks++; if (alu_a !== 8'h0F) begin $display("[TB] FAIL basic_alu_a got %h exp 0f", alu_a); errors++; end
    checks++; if (alu_b !== 8'h11) begin $display("[TB] FAIL basic_alu_b got %h exp 11", alu_b); errors++; end
    checks++; if (alu_sel !== 3'd1) begin $display("[TB] FAIL basic_alu_sel got %0d exp 1", alu_sel); errors++; end
    checks++; if (dout_valid !== 1'b0) begin $display("[TB] FAIL basic_valid_early got %b exp 0", dout_valid); errors++; end
    checks++; if (busy !== 1'b1) begin $display("[TB] FAIL basic_busy_exec got %b exp 1", busy); errors++; end
    @(negedge clk);
    checks++; if (dout_valid !== 1'b1) begin $display("[TB] FAIL basic_valid got %b exp 1", dout_valid); errors++; end
    checks++; if (dout !== 8'h20) begin $display("[TB] FAIL basic_dout got %h exp 20", dout); errors++; end
    checks++; if (dout_cout !== 1'b0) begin $display("[TB] FAIL basic_cout got %b exp 0", dout_cout); errors++; end
    checks++; if (busy !== 1'b0) begin $display("[TB] FAIL basic_busy_done got %b exp 0", busy); errors++; end
  endtask

  task automatic test_carry;
    send_byte(8'h00);
    checks++; if (dout_valid !== 1'b0) begin $display("[TB] FAIL carry_valid_drop got %b exp 0", dout_valid); errors++; end
    send_byte(8'hFF);
    send_byte(8'h02);
    checks++; if (alu_sel !== 3'd0) begin $display("[TB] FAIL carry_sel got %0d exp 0", alu_sel); errors++; end
    @(negedge clk);
    checks++; if (dout !== 8'h01) begin $display("[TB] FAIL carry_dout got %h exp 01", dout); errors++; end
    checks++; if (dout_cout !== 1'b1) begin $display("[TB] FAIL carry_cout got %b exp 1", dout_cout); errors++; end
    checks++; if (dout_valid !== 1'b1) begin $display("[TB] FAIL carry_valid got %b exp 1", dout_valid); errors++; end
  endtask

  task automatic test_done_restart;
    send_byte(8'h03);
    checks++; if (dout_valid !== 1'b0) begin $display("[TB] FAIL restart_valid got %b exp 0", dout_valid); errors++; end
    checks++; if (busy !== 1'b1) begin $display("[TB] FAIL restart_busy got %b exp 1", busy); errors++; end
    checks++; if (alu_sel !== 3'd3) begin $display("[TB] FAIL restart_sel got %0d exp 3", alu_sel); errors++; end
    checks++; if ({dout, dout_cout} !== {8'h01, 1'b1}) begin $display("[TB] FAIL restart_hold got %h/%b exp 01/1", dout, dout_cout); errors++; end
    send_byte(8'h05);
    checks++; if (alu_a !== 8'h05) begin $display("[TB] FAIL restart_alu_a got %h exp 05", alu_a); errors++; end
    send_byte(8'h06);
    checks++; if ({dout, dout_cout} !== {8'h01, 1'b1}) begin $display("[TB] FAIL exec_hold got %h/%b exp 01/1", dout, dout_cout); errors++; end
    @(negedge clk);
    checks++; if ({dout, dout_cout, dout_valid} !== {8'h0B, 1'b0, 1'b1}) begin $display("[TB] FAIL restart_result got %h/%b/%b exp 0b/0/1", dout, dout_cout, dout_valid); errors++; end
    send_byte(8'hFD);
    checks++; if (alu_sel !== 3'd5) begin $display("[TB] FAIL header_fd_sel got %0d exp 5", alu_sel); errors++; end
  endtask

  task automatic test_ena_freeze;
    send_byte(8'h30);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ena    = 1'b0;
      strobe = i[0];
      din    = 8'h99;
    end
    @(negedge clk);
    checks++; if (alu_b !== 8'h06) begin $display("[TB] FAIL freeze_alu_b got %h exp 06", alu_b); errors++; end
    checks++; if (alu_a !== 8'h30) begin $display("[TB] FAIL freeze_alu_a got %h exp 30", alu_a); errors++; end
    checks++; if ({busy, dout_valid, err} !== 3'b100) begin $display("[TB] FAIL freeze_flags got %b exp 100", {busy, dout_valid, err}); errors++; end
    ena    = 1'b1;
    strobe = 1'b0;
    din    = 8'h00;
    send_byte(8'h40);
    @(negedge clk);
    checks++; if ({dout, dout_cout, dout_valid} !== {8'h70, 1'b0, 1'b1}) begin $display("[TB] FAIL freeze_result got %h/%b/%b exp 70/0/1", dout, dout_cout, dout_valid); errors++; end
  endtask

  task automatic test_reset_mid_load;
    send_byte(8'h02);
    send_byte(8'h55);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin $display("[TB] FAIL midrst_busy got %b exp 0", busy); errors++; end
    checks++; if ({alu_a, alu_b, alu_sel} !== 19'h0) begin $display("[TB] FAIL midrst_operands got %h %h %h exp 0", alu_a, alu_b, alu_sel); errors++; end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({dout_valid, busy, dout} !== 10'h0) begin $display("[TB] FAIL midrst_after got %b/%b/%h exp 0/0/00", dout_valid, busy, dout); errors++; end
  endtask

  task automatic test_timeout;
    int err_pulses;
    err_pulses = 0;
    send_byte(8'h01);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (err === 1'b1) err_pulses++;
      checks++; if (busy !== 1'b1) begin $display("[TB] FAIL timeout_wait%0d_busy got %b exp 1", i, busy); errors++; end
    end
    @(negedge clk);
    if (err === 1'b1) err_pulses++;
`ifdef ALU_LOADER_TIMEOUT_EN
    checks++; if (err !== 1'b1) begin $display("[TB] FAIL timeout_err got %b exp 1", err); errors++; end
    checks++; if (busy !== 1'b0) begin $display("[TB] FAIL timeout_busy got %b exp 0", busy); errors++; end
`else
    checks++; if (err !== 1'b0) begin $display("[TB] FAIL notimeout_err got %b exp 0", err); errors++; end
    checks++; if (busy !== 1'b1) begin $display("[TB] FAIL notimeout_busy got %b exp 1", busy); errors++; end
`endif
    repeat (4) begin
      @(negedge clk);
      if (err === 1'b1) err_pulses++;
    end
`ifdef ALU_LOADER_TIMEOUT_EN
    checks++; if (err_pulses != 1) begin $display("[TB] FAIL timeout_pulses got %0d exp 1", err_pulses); errors++; end
    checks++; if (alu_a !== 8'h00) begin $display("[TB] FAIL timeout_alu_a got %h exp 00", alu_a); errors++; end
`else
    checks++; if (err_pulses != 0) begin $display("[TB] FAIL notimeout_pulses got %0d exp 0", err_pulses); errors++; end
    checks++; if (busy !== 1'b1) begin $display("[TB] FAIL notimeout_still_busy got %b exp 1", busy); errors++; end
`endif
  endtask

  initial begin
    test_reset;
    test_basic_add;
    test_carry;
    test_done_restart;
    test_ena_freeze;
    test_reset_mid_load;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
